// File: rtl/axis_pps_tagger_pkg.sv
// Shared types and record layout helpers for the PPS interval tagger.
// Optional timeout logic is built only with AXIS_PPS_TAGGER_TIMEOUT_EN.
package axis_pps_tagger_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOST = 2'd2
  } chan_state_e;

  localparam int REC_CNT_LSB = 0;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rec_ch_lsb(input int cw);
    return cw;
  endfunction

  function automatic int rec_ovr_bit(input int cw, input int chw);
    return cw + chw;
  endfunction

  function automatic int rec_to_bit(input int cw, input int chw);
    return cw + chw + 1;
  endfunction

endpackage

// File: rtl/axis_pps_tagger_chan.sv
// One PPS channel: synchroniser, edge detect, state, counter, holding register.
// Timeout detection exists only with AXIS_PPS_TAGGER_TIMEOUT_EN defined.
module axis_pps_tagger_chan
  import axis_pps_tagger_pkg::*;
#(
  parameter int CNTR_WIDTH  = 32,
  parameter int SYNC_STAGES = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  pps,
  input  logic                  enable,
  input  logic                  polarity,
  input  logic [CNTR_WIDTH-1:0] timeout,
  input  logic                  take,
  output logic                  pend,
  output logic [CNTR_WIDTH-1:0] pend_cnt,
  output logic                  pend_ovr,
  output logic                  pend_to,
  output logic                  locked
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   act;
  logic                   act_d;
  logic                   edge_r;
  chan_state_e            state;
  logic [CNTR_WIDTH-1:0]  cnt;
  logic [CNTR_WIDTH-1:0]  cnt_inc;
  logic                   to_hit;
  logic                   rec_vld;
  logic                   rec_to;

  assign act     = sync[SYNC_STAGES-1] ^ polarity;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign locked  = (state == ST_RUN);

`ifdef AXIS_PPS_TAGGER_TIMEOUT_EN
  assign to_hit = (timeout != '0) && (cnt_inc == timeout);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync   <= '0;
      act_d  <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pps};
      act_d  <= act;
      edge_r <= act & ~act_d;
    end
  end

  // A period edge takes priority over a coincident timeout.
  always_comb begin
    rec_vld = 1'b0;
    rec_to  = 1'b0;
    if (enable && state == ST_RUN) begin
      if (edge_r) begin
        rec_vld = 1'b1;
      end else if (to_hit) begin
        rec_vld = 1'b1;
        rec_to  = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else if (!enable) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      cnt <= edge_r ? '0 : cnt_inc;
      unique case (state)
        ST_WAIT: if (edge_r) state <= ST_RUN;
        ST_RUN:  if (!edge_r && to_hit) state <= ST_LOST;
        ST_LOST: if (edge_r) state <= ST_RUN;
        default: state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend     <= 1'b0;
      pend_cnt <= '0;
      pend_ovr <= 1'b0;
      pend_to  <= 1'b0;
    end else if (!enable) begin
      pend     <= 1'b0;
      pend_ovr <= 1'b0;
    end else if (rec_vld) begin
      pend     <= 1'b1;
      pend_cnt <= cnt_inc;
      pend_to  <= rec_to;
      pend_ovr <= pend && !take;
    end else if (take) begin
      pend     <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_pps_tagger.sv
// Multi-channel PPS interval tagger with round-robin AXI-Stream output.
// Define AXIS_PPS_TAGGER_TIMEOUT_EN to build missing-pulse detection.
module axis_pps_tagger
  import axis_pps_tagger_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int CNTR_WIDTH       = 32,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int SYNC_STAGES      = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CHANNELS-1:0]         pps_data,
  input  logic [CHANNELS-1:0]         cfg_enable,
  input  logic [CHANNELS-1:0]         cfg_polarity,
  input  logic [CNTR_WIDTH-1:0]       cfg_timeout,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [CHANNELS-1:0]         sts_locked
);

  localparam int CH_W    = ch_w(CHANNELS);
  localparam int CH_LSB  = rec_ch_lsb(CNTR_WIDTH);
  localparam int OVR_BIT = rec_ovr_bit(CNTR_WIDTH, CH_W);
  localparam int TO_BIT  = rec_to_bit(CNTR_WIDTH, CH_W);

  logic [CHANNELS-1:0]         pend;
  logic [CHANNELS-1:0]         pend_ovr;
  logic [CHANNELS-1:0]         pend_to;
  logic [CHANNELS-1:0]         take;
  logic [CNTR_WIDTH-1:0]       pend_cnt [CHANNELS];
  logic [CH_W-1:0]             ptr;
  logic [CH_W-1:0]             gnt;
  logic                        gnt_vld;
  logic                        load;
  logic [AXIS_TDATA_WIDTH-1:0] rec;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    axis_pps_tagger_chan #(
      .CNTR_WIDTH (CNTR_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .aclk    (aclk),
      .aresetn (aresetn),
      .pps     (pps_data[gi]),
      .enable  (cfg_enable[gi]),
      .polarity(cfg_polarity[gi]),
      .timeout (cfg_timeout),
      .take    (take[gi]),
      .pend    (pend[gi]),
      .pend_cnt(pend_cnt[gi]),
      .pend_ovr(pend_ovr[gi]),
      .pend_to (pend_to[gi]),
      .locked  (sts_locked[gi])
    );
  end

  assign load = !m_axis_tvalid || m_axis_tready;

  // ptr holds the first channel to consider; search ptr..N-1 then 0..ptr-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!gnt_vld && pend[i] && i >= int'(ptr)) begin
        gnt_vld = 1'b1;
        gnt     = CH_W'(i);
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!gnt_vld && pend[i] && i < int'(ptr)) begin
        gnt_vld = 1'b1;
        gnt     = CH_W'(i);
      end
    end
  end

  always_comb begin
    take = '0;
    if (load && gnt_vld) take[gnt] = 1'b1;
  end

  always_comb begin
    rec = '0;
    rec[REC_CNT_LSB +: CNTR_WIDTH] = pend_cnt[gnt];
    rec[CH_LSB +: CH_W]            = gnt;
    rec[OVR_BIT]                   = pend_ovr[gnt];
    rec[TO_BIT]                    = pend_to[gnt];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load) begin
      m_axis_tvalid <= gnt_vld;
      if (gnt_vld) begin
        m_axis_tdata <= rec;
        ptr <= (gnt == CH_W'(CHANNELS - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pps_tagger.sv
// Directed self-checking bench for axis_pps_tagger.
// Timeout scenario expectations follow AXIS_PPS_TAGGER_TIMEOUT_EN.
module tb_axis_pps_tagger;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  pps_data;
  logic [3:0]  cfg_enable;
  logic [3:0]  cfg_polarity;
  logic [31:0] cfg_timeout;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [3:0]  sts_locked;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] q[$];
  int          qt[$];

  axis_pps_tagger dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .pps_data     (pps_data),
    .cfg_enable   (cfg_enable),
    .cfg_polarity (cfg_polarity),
    .cfg_timeout  (cfg_timeout),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .sts_locked   (sts_locked)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      q.push_back(m_axis_tdata);
      qt.push_back(cyc);
    end
  end

  function automatic logic [63:0] exp_rec(input int cnt, input int ch,
                                          input bit ovr, input bit to);
    logic [63:0] r;
    r        = '0;
    r[31:0]  = cnt;
    r[33:32] = ch[1:0];
    r[34]    = ovr;
    r[35]    = to;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic train(input int ch, input int n, input int period,
                       input int act, input logic lvl);
    for (int i = 0; i < n; i++) begin
      pps_data[ch] = lvl;
      tick(act);
      pps_data[ch] = ~lvl;
      tick(period - act);
    end
  endtask

  task automatic test_reset;
    aresetn       = 1'b0;
    pps_data      = '0;
    cfg_enable    = '0;
    cfg_polarity  = '0;
    cfg_timeout   = '0;
    m_axis_tready = 1'b1;
    tick(3);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid);
    end
    checks++;
    if (m_axis_tdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_tdata: got %h want 0", m_axis_tdata);
    end
    checks++;
    if (sts_locked !== 4'd0) begin
      failures++;
      $display("FAIL reset_locked: got %b want 0000", sts_locked);
    end
    aresetn = 1'b1;
    tick(5);
  endtask

  task automatic test_period;
    cfg_enable = 4'b0001;
    q.delete();
    qt.delete();
    train(0, 3, 1000, 100, 1'b1);
    tick(20);
    checks++;
    if (q.size() !== 2) begin
      failures++;
      $display("FAIL period_count: got %0d records want 2", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i] !== exp_rec(1000, 0, 0, 0)) begin
        failures++;
        $display("FAIL period_rec%0d: got %h want %h", i, q[i],
                 exp_rec(1000, 0, 0, 0));
      end
    end
    checks++;
    if (sts_locked[0] !== 1'b1) begin
      failures++;
      $display("FAIL period_locked: got %b want 1", sts_locked[0]);
    end
  endtask

  task automatic test_latency;
    int n;
    cfg_enable = 4'b0000;
    tick(2);
    cfg_enable = 4'b0001;
    tick(2);
    q.delete();
    qt.delete();
    pps_data[0] = 1'b1;
    tick(50);
    pps_data[0] = 1'b0;
    tick(150);
    pps_data[0] = 1'b1;
    n = 0;
    do begin
      @(posedge aclk);
      n++;
      @(negedge aclk);
    end while (!m_axis_tvalid && n < 20);
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL latency: got %0d cycles want 7", n);
    end
    checks++;
    if (m_axis_tdata !== exp_rec(200, 0, 0, 0)) begin
      failures++;
      $display("FAIL latency_rec: got %h want %h", m_axis_tdata,
               exp_rec(200, 0, 0, 0));
    end
    tick(5);
    pps_data[0] = 1'b0;
  endtask

  task automatic test_disable;
    cfg_enable = 4'b0000;
    tick(1);
    checks++;
    if (sts_locked[0] !== 1'b0) begin
      failures++;
      $display("FAIL disable_locked: got %b want 0", sts_locked[0]);
    end
    tick(5);
  endtask

  task automatic test_timeout;
    cfg_enable  = 4'b0010;
    cfg_timeout = 32'd1500;
    q.delete();
    qt.delete();
    train(1, 3, 1000, 100, 1'b1);
    tick(600);
`ifdef AXIS_PPS_TAGGER_TIMEOUT_EN
    checks++;
    if (q.size() !== 3) begin
      failures++;
      $display("FAIL timeout_count: got %0d records want 3", q.size());
    end
    if (q.size() == 3) begin
      checks++;
      if (q[2] !== exp_rec(1500, 1, 0, 1)) begin
        failures++;
        $display("FAIL timeout_rec: got %h want %h", q[2],
                 exp_rec(1500, 1, 0, 1));
      end
    end
    checks++;
    if (sts_locked[1] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_unlocked: got %b want 0", sts_locked[1]);
    end
    pps_data[1] = 1'b1;
    tick(20);
    checks++;
    if (q.size() !== 3) begin
      failures++;
      $display("FAIL relock_norec: got %0d records want 3", q.size());
    end
`else
    checks++;
    if (q.size() !== 2) begin
      failures++;
      $display("FAIL timeout_off_count: got %0d records want 2", q.size());
    end
    checks++;
    if (sts_locked[1] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_off_locked: got %b want 1", sts_locked[1]);
    end
    pps_data[1] = 1'b1;
    tick(20);
`endif
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      checks++;
      if (q[i] !== exp_rec(1000, 1, 0, 0)) begin
        failures++;
        $display("FAIL timeout_period%0d: got %h want %h", i, q[i],
                 exp_rec(1000, 1, 0, 0));
      end
    end
    checks++;
    if (sts_locked[1] !== 1'b1) begin
      failures++;
      $display("FAIL relock_locked: got %b want 1", sts_locked[1]);
    end
    pps_data[1] = 1'b0;
    cfg_timeout = '0;
    cfg_enable  = '0;
    tick(5);
  endtask

  task automatic test_burst;
    aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
    cfg_enable = 4'b1111;
    tick(10);
    q.delete();
    qt.delete();
    for (int b = 0; b < 3; b++) begin
      pps_data = 4'b1111;
      tick(100);
      pps_data = 4'b0000;
      tick(100);
    end
    tick(20);
    checks++;
    if (q.size() !== 8) begin
      failures++;
      $display("FAIL burst_count: got %0d records want 8", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i] !== exp_rec(200, i % 4, 0, 0)) begin
        failures++;
        $display("FAIL burst_rec%0d: got %h want %h", i, q[i],
                 exp_rec(200, i % 4, 0, 0));
      end
      if (i % 4 != 0) begin
        checks++;
        if (qt[i] !== qt[i-1] + 1) begin
          failures++;
          $display("FAIL burst_gap%0d: got cycle %0d want %0d", i, qt[i],
                   qt[i-1] + 1);
        end
      end
    end
    cfg_enable = '0;
    tick(5);
  endtask

  task automatic test_stall;
    logic [63:0] td0;
    cfg_enable    = 4'b0100;
    m_axis_tready = 1'b0;
    q.delete();
    qt.delete();
    train(2, 2, 500, 50, 1'b1);
    td0 = m_axis_tdata;
    checks++;
    if (m_axis_tvalid !== 1'b1 || td0 !== exp_rec(500, 2, 0, 0)) begin
      failures++;
      $display("FAIL stall_first: got v=%b %h want v=1 %h", m_axis_tvalid,
               td0, exp_rec(500, 2, 0, 0));
    end
    train(2, 2, 500, 50, 1'b1);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== td0) begin
      failures++;
      $display("FAIL stall_stable: got v=%b %h want v=1 %h", m_axis_tvalid,
               m_axis_tdata, td0);
    end
    m_axis_tready = 1'b1;
    tick(5);
    checks++;
    if (q.size() !== 2) begin
      failures++;
      $display("FAIL stall_count: got %0d records want 2", q.size());
    end
    if (q.size() == 2) begin
      checks++;
      if (q[0] !== exp_rec(500, 2, 0, 0)) begin
        failures++;
        $display("FAIL stall_rec0: got %h want %h", q[0],
                 exp_rec(500, 2, 0, 0));
      end
      checks++;
      if (q[1] !== exp_rec(500, 2, 1, 0)) begin
        failures++;
        $display("FAIL stall_ovr: got %h want %h", q[1],
                 exp_rec(500, 2, 1, 0));
      end
    end
    cfg_enable = '0;
    tick(5);
  endtask

  task automatic test_polarity_reset;
    cfg_polarity = 4'b1000;
    pps_data[3]  = 1'b1;
    tick(10);
    cfg_enable = 4'b1000;
    tick(2);
    q.delete();
    qt.delete();
    train(3, 1, 1000, 300, 1'b0);
    pps_data[3] = 1'b0;
    tick(20);
    checks++;
    if (q.size() !== 1) begin
      failures++;
      $display("FAIL pol_count: got %0d records want 1", q.size());
    end
    if (q.size() == 1) begin
      checks++;
      if (q[0] !== exp_rec(1000, 3, 0, 0)) begin
        failures++;
        $display("FAIL pol_rec: got %h want %h", q[0],
                 exp_rec(1000, 3, 0, 0));
      end
    end
    tick(280);
    pps_data[3] = 1'b1;
    tick(700);
    m_axis_tready = 1'b0;
    pps_data[3] = 1'b0;
    tick(20);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_rec(1000, 3, 0, 0)) begin
      failures++;
      $display("FAIL pol_stalled: got v=%b %h want v=1 %h", m_axis_tvalid,
               m_axis_tdata, exp_rec(1000, 3, 0, 0));
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_tvalid: got %b want 0", m_axis_tvalid);
    end
    checks++;
    if (sts_locked !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_locked: got %b want 0000", sts_locked);
    end
    tick(2);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    tick(50);
    checks++;
    if (q.size() !== 1 || m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL no_stale: got %0d records v=%b want 1 records v=0",
               q.size(), m_axis_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_latency();
    test_disable();
    test_timeout();
    test_burst();
    test_stall();
    test_polarity_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pps_tagger.md
AXIS_PPS_TAGGER -- requirements
Module: axis_pps_tagger

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of independent PPS inputs (1..16).
REQ-002 SHALL have parameter CNTR_WIDTH, default 32, meaning interval counter width.
REQ-003 SHALL have parameter AXIS_TDATA_WIDTH, default 64, meaning output width; must be >= CNTR_WIDTH+CH_W+2, where CH_W = max(1, clog2(CHANNELS)).
REQ-004 SHALL have parameter SYNC_STAGES, default 4, meaning input synchroniser depth (2..8).
REQ-005 SHALL have port aclk  input  1  clock; all logic is in this single domain.
REQ-006 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pps_data  input  CHANNELS  asynchronous PPS pins.
REQ-008 SHALL have port cfg_enable  input  CHANNELS  per-channel enable.
REQ-009 SHALL have port cfg_polarity  input  CHANNELS  0 = rising edge active, 1 = falling edge active.
REQ-010 SHALL have port cfg_timeout  input  CNTR_WIDTH  missing-pulse limit in cycles; 0 disables it.
REQ-011 SHALL have port m_axis_tdata  output  AXIS_TDATA_WIDTH  record.
REQ-012 SHALL have port m_axis_tvalid  output  1  record valid.
REQ-013 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-014 SHALL have port sts_locked  output  CHANNELS  channel is in RUN.

Function
REQ-015 SHALL pass each pps_data bit through a SYNC_STAGES flip-flop chain, then invert it when cfg_polarity is 1, then detect active edges on a 1-cycle registered compare.
REQ-016 SHALL give each channel states WAIT (no edge seen), RUN and LOST, with disabled channels held in WAIT.
REQ-017 SHALL zero the channel counter on every edge and otherwise increment it, saturating at all-ones without wrap.
REQ-018 SHALL transition WAIT->RUN on the first edge and emit no record for that edge.
REQ-019 SHALL, on an edge in RUN, emit a period record whose count equals counter+1 (saturated), i.e. aclk cycles between edges.
REQ-020 SHALL, in RUN with cfg_timeout != 0 and counter+1 == cfg_timeout, emit a timeout record with count = cfg_timeout and move to LOST.
REQ-021 SHALL, on an edge in LOST, zero the counter, move to RUN and emit no record.
REQ-022 SHALL lay out the record as: bits [CNTR_WIDTH-1:0] count; then CH_W bits channel index; then the overwrite bit; then the timeout bit; zero-filled above.
REQ-023 SHALL give each channel a one-entry holding register; a new record while that register is pending SHALL replace it and set its overwrite bit.
REQ-024 SHALL treat a record produced in the same cycle its pending entry is taken by the output stage as a load, not an overwrite.
REQ-025 SHALL use a round-robin arbiter, starting after the last granted channel, to move one pending entry per cycle into the output register when !m_axis_tvalid or m_axis_tready.
REQ-026 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready.
REQ-027 SHALL have a latency of 3 aclk cycles, from the synchroniser output changing to m_axis_tvalid rising, when the channel and output are idle.
REQ-028 SHALL, on cfg_enable bit falling, return that channel to WAIT on the next cycle, clear its counter and discard its pending entry; a record already in the output register is unaffected.
REQ-029 SHALL drive sts_locked[i] high only in RUN.

Reset
REQ-030 SHALL, on aresetn low, asynchronously clear the synchronisers, counters, pending flags, arbiter pointer (to channel 0) and output register; m_axis_tvalid=0, m_axis_tdata=0, sts_locked=0, all channels in WAIT.
REQ-031 SHALL, on reset asserted mid-transfer, drop any in-flight record without replay.

Configuration
REQ-032 SHALL compile the timeout logic only with macro AXIS_PPS_TAGGER_TIMEOUT_EN; without it, cfg_timeout is ignored, LOST is unreachable and the timeout bit is constant 0.

Structure
REQ-033 SHALL place the channel state encoding (WAIT/RUN/LOST), record field offsets and the CH_W function in package axis_pps_tagger_pkg.
REQ-034 SHALL implement the synchroniser, edge detect, state machine, counter and holding register in sub-module axis_pps_tagger_chan, instantiated CHANNELS times.

Verification
REQ-035 SHALL cover: ch0 rising edges 1000 cycles apart, tready=1 -> first edge no record, then records count=1000, channel=0, flags=0.
REQ-036 SHALL cover: cfg_timeout=1500, ch1 edges stop after 2 periods of 1000 -> one record count=1500, timeout=1, sts_locked[1]=0; next edge -> no record, locked=1.
REQ-037 SHALL cover: all 4 channels edge in the same cycle, tready=1 -> 4 records on consecutive cycles in channel order 0,1,2,3, then next burst starting at 0 after last grant 3.
REQ-038 SHALL cover: tready=0 across two ch2 periods of 500 -> on release, ch2 record count=500 with overwrite=1, and tdata stable while stalled.
REQ-039 SHALL cover: cfg_polarity[3]=1 with a 300-cycle-low pulse train -> intervals measured falling-to-falling; aresetn pulsed mid-stream -> tvalid=0 immediately, no stale record after release.
